hazard_stall_controller: RTL and testbench
==========================================

# hazard_stall_controller

Pipeline hazard controller for the 5-stage MIPS core: detects load-use hazards that forwarding cannot cover, sequences the multi-cycle HI/LO multiply/divide unit, and kills wrong-path instructions after taken branches/jumps. Sits between decode and the IF/ID and ID/EX pipeline registers. Drives the PC, IF/ID and ID/EX write/flush controls and the mul/div start strobe.

## Interface
- MUL_CYCLES, 4: multiply latency in cycles (1..64)
- DIV_CYCLES, 32: divide latency in cycles (1..64)

- Clk  in  1  pipeline clock, rising edge
- Rst_n  in  1  asynchronous, active-low reset
- ID_Instruction  in  32  instruction in decode
- EX_MemRead  in  1  EX-stage instruction is a load (lw/lh/lb)
- EX_RegisterRd  in  5  EX-stage destination register
- EX_BranchTaken  in  1  branch/jump resolved taken in EX
- ID_MulDivReq  in  1  decode holds mult/multu/div/divu
- ID_IsDiv  in  1  qualifies ID_MulDivReq as a divide
- ID_UsesHiLo  in  1  decode holds mfhi/mflo/mthi/mtlo or a mult/div
- PCWrite  out  1  PC update enable
- IFID_Write  out  1  IF/ID register load enable
- IFID_Flush  out  1  clear IF/ID to nop
- IDEX_Bubble  out  1  load nop control into ID/EX
- MulDivStart  out  1  one-cycle start pulse to HI/LO unit
- MulDivBusy  out  1  HI/LO unit operating

## Operation
- Fields: Rs = ID_Instruction[25:21], Rt = [20:16], Opcode = [31:26].
- UsesRt = Opcode in {000000, 011100, 000100, 000101, 101011, 101000, 101001}.
- LoadUse = EX_MemRead && EX_RegisterRd != 0 && (EX_RegisterRd == Rs || (UsesRt && EX_RegisterRd == Rt)).
- HiLoStall = MulDivBusy && ID_UsesHiLo.
- Stall = (LoadUse || HiLoStall) && !EX_BranchTaken.
- Stall: PCWrite=0, IFID_Write=0, IDEX_Bubble=1, IFID_Flush=0.
- EX_BranchTaken (highest priority): PCWrite=1, IFID_Write=1, IFID_Flush=1, IDEX_Bubble=1; overrides any stall.
- Otherwise: PCWrite=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- FSM states IDLE, BUSY; 6-bit down-counter Cnt.
- Accept = state IDLE && ID_MulDivReq && !Stall && !EX_BranchTaken.
- IDLE: on Accept -> BUSY, Cnt <= (ID_IsDiv ? DIV_CYCLES : MUL_CYCLES) - 1, MulDivStart <= 1.
- BUSY: Cnt==0 -> IDLE; else Cnt <= Cnt-1. MulDivStart <= 0.
- MulDivBusy = (state == BUSY), registered.
- A second mult/div arriving while BUSY stalls via ID_UsesHiLo; accepted the cycle after BUSY ends.

## Timing
- Reset values (while Rst_n low, asynchronously): state IDLE, Cnt=0, MulDivStart=0, MulDivBusy=0, PCWrite=0, IFID_Write=0, IFID_Flush=0, IDEX_Bubble=1.
- Stall/flush outputs combinational from inputs and current state; no added latency.
- Load-use stall lasts exactly 1 cycle (load advances to MEM; forwarding covers it after).
- Mul/div in ID at cycle T: MulDivStart high in T+1 only; MulDivBusy high T+1..T+N (N = selected latency); dependent HI/LO instruction in ID is released at T+N+1.
- N=1: BUSY for exactly one cycle.
- Reset asserted mid-BUSY: operation abandoned, IDLE immediately; no start pulse after release until a new Accept.
- Branch taken with mul/div in ID: no Accept, no start pulse.
- Branch taken while BUSY: mul/div already issued continues to completion (HI/LO written architecturally).

## Configuration
- HAZARD_STALL_COUNT_EN defined: adds output StallCycles (32-bit), reset 0, +1 every cycle Stall=1, saturates at 0xFFFFFFFF, never wraps.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- Reset: Rst_n=0 mid-BUSY with Cnt=10 -> outputs at reset values immediately; after release, MulDivBusy=0, MulDivStart=0.
- Load-use: EX lw to $8, ID add $9,$8,$10 -> one cycle PCWrite=0, IFID_Write=0, IDEX_Bubble=1; next cycle all normal. Same with EX_RegisterRd=0 -> no stall; ID addi using $8 only as Rt -> no stall.
- Multiply: mult at T, MUL_CYCLES=4, mflo at T+1 -> MulDivStart at T+1, MulDivBusy T+1..T+4, stall T+1..T+4, mflo advances T+5.
- Divide back-to-back: div then mult, DIV_CYCLES=32 -> mult stalled 32 cycles, its MulDivStart one cycle after MulDivBusy falls.
- Branch priority: EX_BranchTaken=1 with LoadUse=1 and ID_MulDivReq=1 -> PCWrite=1, IFID_Flush=1, IDEX_Bubble=1, no MulDivStart next cycle.
- HAZARD_STALL_COUNT_EN: 3 load-use stalls + 4-cycle HI/LO stall -> StallCycles=7; preset near max -> holds 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Load-use / HI-LO hazard stalls, branch flush and mul/div sequencing.
// Optional HAZARD_STALL_COUNT_EN adds a saturating StallCycles counter.
module hazard_stall_controller #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] ID_Instruction,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_RegisterRd,
    input  logic        EX_BranchTaken,
    input  logic        ID_MulDivReq,
    input  logic        ID_IsDiv,
    input  logic        ID_UsesHiLo,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        MulDivStart,
    output logic        MulDivBusy
`ifdef HAZARD_STALL_COUNT_EN
    ,
    output logic [31:0] StallCycles
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_nxt;
    logic       r_start;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_uses_rt;
    logic       w_load_use;
    logic       w_hilo_stall;
    logic       w_stall;
    logic       w_accept;
    logic       w_unused;

    assign w_op     = ID_Instruction[31:26];
    assign w_rs     = ID_Instruction[25:21];
    assign w_rt     = ID_Instruction[20:16];
    assign w_unused = ^ID_Instruction[15:0];

    // Opcodes that read Rt as a source (R-type, SPECIAL2, branches, stores)
    always_comb begin
        w_uses_rt = 1'b0;
        case (w_op)
            6'b000000, 6'b011100, 6'b000100, 6'b000101,
            6'b101011, 6'b101000, 6'b101001: w_uses_rt = 1'b1;
            default:                         w_uses_rt = 1'b0;
        endcase
    end

    assign w_load_use = EX_MemRead && (EX_RegisterRd != 5'd0) &&
                        ((EX_RegisterRd == w_rs) ||
                         (w_uses_rt && (EX_RegisterRd == w_rt)));
    assign w_hilo_stall = MulDivBusy && ID_UsesHiLo;
    assign w_stall  = (w_load_use || w_hilo_stall) && !EX_BranchTaken;
    assign w_accept = (r_state == S_IDLE) && ID_MulDivReq &&
                      !w_stall && !EX_BranchTaken;

    // State, latency counter and start pulse registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_start <= w_accept;
        end
    end

    // Next-state: load latency on accept, count down while busy
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = ID_IsDiv ? DIV_LOAD : MUL_LOAD;
                end
            end
            S_BUSY: begin
                if (r_cnt == 6'd0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 6'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 6'd0;
            end
        endcase
    end

    // Pipeline controls: reset, then branch flush, then stall, else run
    always_comb begin
        PCWrite     = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        unique case (1'b1)
            !Rst_n: begin
                PCWrite     = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
            end
            EX_BranchTaken: begin
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
            end
            w_stall: begin
                PCWrite     = 1'b0;
                IFID_Write  = 1'b0;
                IDEX_Bubble = 1'b1;
            end
            default: begin
                PCWrite = 1'b1;
            end
        endcase
    end

    assign MulDivBusy  = (r_state == S_BUSY);
    assign MulDivStart = r_start;

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of stalled cycles
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign StallCycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: vector table, corner sequences
// and randomized run against a cycle-count reference model.
module tb_hazard_stall_controller;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic [31:0] ID_Instruction = '0;
    logic        EX_MemRead = 1'b0;
    logic [4:0]  EX_RegisterRd = '0;
    logic        EX_BranchTaken = 1'b0;
    logic        ID_MulDivReq = 1'b0;
    logic        ID_IsDiv = 1'b0;
    logic        ID_UsesHiLo = 1'b0;
    logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble;
    logic        MulDivStart, MulDivBusy;
    logic        pcw1, ifw1, fl1, bub1, start1, busy1;
`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] StallCycles, sc1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    hazard_stall_controller #(.MUL_CYCLES(4), .DIV_CYCLES(32)) u_dut (
        .Clk(Clk), .Rst_n(Rst_n), .ID_Instruction(ID_Instruction),
        .EX_MemRead(EX_MemRead), .EX_RegisterRd(EX_RegisterRd),
        .EX_BranchTaken(EX_BranchTaken), .ID_MulDivReq(ID_MulDivReq),
        .ID_IsDiv(ID_IsDiv), .ID_UsesHiLo(ID_UsesHiLo),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write),
        .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
        .MulDivStart(MulDivStart), .MulDivBusy(MulDivBusy)
`ifdef HAZARD_STALL_COUNT_EN
        , .StallCycles(StallCycles)
`endif
    );

    hazard_stall_controller #(.MUL_CYCLES(1), .DIV_CYCLES(64)) u_n1 (
        .Clk(Clk), .Rst_n(Rst_n), .ID_Instruction(ID_Instruction),
        .EX_MemRead(EX_MemRead), .EX_RegisterRd(EX_RegisterRd),
        .EX_BranchTaken(EX_BranchTaken), .ID_MulDivReq(ID_MulDivReq),
        .ID_IsDiv(ID_IsDiv), .ID_UsesHiLo(ID_UsesHiLo),
        .PCWrite(pcw1), .IFID_Write(ifw1),
        .IFID_Flush(fl1), .IDEX_Bubble(bub1),
        .MulDivStart(start1), .MulDivBusy(busy1)
`ifdef HAZARD_STALL_COUNT_EN
        , .StallCycles(sc1)
`endif
    );

    typedef struct {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       mr;
        logic [4:0] rd;
        logic       br;
        logic [3:0] exp;
    } vec_t;

    vec_t vt[10];

    function automatic logic [31:0] mk(input logic [5:0] op,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt);
        return {op, rs, rt, 16'h0020};
    endfunction

    function automatic logic [3:0] outs();
        return {PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic mr,
                        input logic [4:0] rd, input logic br,
                        input logic req, input logic isdiv,
                        input logic hilo);
        @(negedge Clk);
        ID_Instruction = ins;
        EX_MemRead     = mr;
        EX_RegisterRd  = rd;
        EX_BranchTaken = br;
        ID_MulDivReq   = req;
        ID_IsDiv       = isdiv;
        ID_UsesHiLo    = hilo;
        #1;
    endtask

    task automatic nop();
        step(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Rst_n = 1'b0;
        ID_Instruction = '0;
        EX_MemRead = 1'b0;
        EX_RegisterRd = '0;
        EX_BranchTaken = 1'b0;
        ID_MulDivReq = 1'b0;
        ID_IsDiv = 1'b0;
        ID_UsesHiLo = 1'b0;
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    // Reference: which opcodes read Rt
    function automatic bit ref_uses_rt(input logic [5:0] op);
        return op inside {6'h00, 6'h1c, 6'h04, 6'h05, 6'h2b, 6'h28, 6'h29};
    endfunction

    logic [31:0] mult_i, div_i, mflo_i, add_i;
    logic [5:0]  ops[11];
    int          rem;
    bit          start_m;
    longint      sc_m;

    initial begin
        mult_i = mk(6'h00, 5'd8, 5'd9);
        div_i  = mk(6'h00, 5'd10, 5'd11);
        mflo_i = mk(6'h00, 5'd0, 5'd0);
        add_i  = mk(6'h00, 5'd8, 5'd10);
        ops = '{6'h00, 6'h1c, 6'h04, 6'h05, 6'h2b, 6'h28, 6'h29,
                6'h23, 6'h08, 6'h0d, 6'h02};

        vt[0] = '{6'h00, 5'd8, 5'd10, 1'b1, 5'd8, 1'b0, 4'b0001};
        vt[1] = '{6'h00, 5'd0, 5'd10, 1'b1, 5'd0, 1'b0, 4'b1100};
        vt[2] = '{6'h08, 5'd9, 5'd8,  1'b1, 5'd8, 1'b0, 4'b1100};
        vt[3] = '{6'h2b, 5'd9, 5'd8,  1'b1, 5'd8, 1'b0, 4'b0001};
        vt[4] = '{6'h04, 5'd9, 5'd8,  1'b1, 5'd8, 1'b0, 4'b0001};
        vt[5] = '{6'h00, 5'd8, 5'd10, 1'b0, 5'd8, 1'b0, 4'b1100};
        vt[6] = '{6'h00, 5'd8, 5'd10, 1'b1, 5'd8, 1'b1, 4'b1111};
        vt[7] = '{6'h02, 5'd1, 5'd2,  1'b0, 5'd0, 1'b1, 4'b1111};
        vt[8] = '{6'h1c, 5'd9, 5'd8,  1'b1, 5'd8, 1'b0, 4'b0001};
        vt[9] = '{6'h23, 5'd9, 5'd8,  1'b1, 5'd8, 1'b0, 4'b1100};

        // Reset values
        #1;
        chk("rst_ctl", 32'(outs()), 32'b0001);
        chk("rst_busy", 32'(MulDivBusy), 0);
        chk("rst_start", 32'(MulDivStart), 0);
        do_reset();

        // Combinational vector table, FSM idle
        for (int i = 0; i < 10; i++) begin
            step(mk(vt[i].op, vt[i].rs, vt[i].rt), vt[i].mr, vt[i].rd,
                 vt[i].br, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
        end

        // Load-use lasts one cycle once the load moves on
        step(add_i, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_stall", 32'(outs()), 32'b0001);
        step(add_i, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lu_release", 32'(outs()), 32'b1100);

        // Multiply then dependent mflo
        do_reset();
        step(mult_i, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("mul_T_run", 32'(outs()), 32'b1100);
        for (int k = 1; k <= 4; k++) begin
            step(mflo_i, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("mul_busy%0d", k), 32'(MulDivBusy), 1);
            chk($sformatf("mul_start%0d", k), 32'(MulDivStart),
                (k == 1) ? 1 : 0);
            chk($sformatf("mul_stall%0d", k), 32'(outs()), 32'b0001);
            if (k <= 2)
                chk($sformatf("n1_busy%0d", k), 32'(busy1),
                    (k == 1) ? 1 : 0);
        end
        step(mflo_i, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mul_done_busy", 32'(MulDivBusy), 0);
        chk("mul_done_run", 32'(outs()), 32'b1100);

        // Divide followed by a multiply
        do_reset();
        step(div_i, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("div_T_run", 32'(outs()), 32'b1100);
        for (int k = 1; k <= 32; k++) begin
            step(mult_i, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
            chk($sformatf("div_busy%0d", k), 32'(MulDivBusy), 1);
            chk($sformatf("div_stall%0d", k), 32'(PCWrite), 0);
            chk($sformatf("div_start%0d", k), 32'(MulDivStart),
                (k == 1) ? 1 : 0);
        end
        step(mult_i, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("b2b_idle", 32'(MulDivBusy), 0);
        chk("b2b_run", 32'(PCWrite), 1);
        nop();
        chk("b2b_start", 32'(MulDivStart), 1);
        chk("b2b_busy", 32'(MulDivBusy), 1);

        // Branch beats load-use and mul/div request
        do_reset();
        step(add_i, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("br_prio", 32'(outs()), 32'b1111);
        nop();
        chk("br_nostart", 32'(MulDivStart), 0);
        chk("br_nobusy", 32'(MulDivBusy), 0);

        // Reset mid-divide with Cnt at 10
        do_reset();
        step(div_i, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 21; k++) nop();
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        chk("mrst_ctl", 32'(outs()), 32'b0001);
        chk("mrst_busy", 32'(MulDivBusy), 0);
        chk("mrst_start", 32'(MulDivStart), 0);
        @(negedge Clk);
        Rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nop();
            chk($sformatf("post_busy%0d", k), 32'(MulDivBusy), 0);
            chk($sformatf("post_start%0d", k), 32'(MulDivStart), 0);
        end

`ifdef HAZARD_STALL_COUNT_EN
        // Three load-use stalls plus a four-cycle HI/LO stall
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(add_i, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
            nop();
        end
        step(mult_i, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++)
            step(mflo_i, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        nop();
        chk("stall_count", StallCycles, 32'd7);
`endif

        // Randomized run against the latency model
        do_reset();
        rem = 0;
        start_m = 0;
        sc_m = 0;
        for (int c = 0; c < 600; c++) begin
            logic [5:0] op;
            logic [4:0] rs, rt, rd;
            logic mr, br, req, isdiv, hilo;
            bit lu, stall;
            op    = ops[$urandom_range(10)];
            rs    = 5'($urandom_range(3));
            rt    = 5'($urandom_range(3));
            rd    = 5'($urandom_range(3));
            mr    = ($urandom_range(9) < 4);
            br    = ($urandom_range(9) == 0);
            req   = ($urandom_range(3) == 0);
            isdiv = ($urandom_range(3) == 0);
            hilo  = req | ($urandom_range(9) < 3);
            step(mk(op, rs, rt), mr, rd, br, req, isdiv, hilo);

            lu = mr && rd != 0 &&
                 (rd == rs || (ref_uses_rt(op) && rd == rt));
            stall = (lu || (rem > 0 && hilo)) && !br;
            chk($sformatf("rnd%0d_ctl", c), 32'(outs()),
                br ? 32'b1111 : (stall ? 32'b0001 : 32'b1100));
            chk($sformatf("rnd%0d_busy", c), 32'(MulDivBusy),
                32'(rem > 0));
            chk($sformatf("rnd%0d_start", c), 32'(MulDivStart),
                32'(start_m));
`ifdef HAZARD_STALL_COUNT_EN
            chk($sformatf("rnd%0d_cnt", c), StallCycles, 32'(sc_m));
`endif
            start_m = (rem == 0) && req && !stall && !br;
            if (rem > 0) rem--;
            else if (start_m) rem = isdiv ? 32 : 4;
            if (stall) sc_m++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
